input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Upstream conditioning stage for the edge detector. Takes a raw asynchronous level (switch, button or external pin) and synchronizes it into clk.
- Rejects glitches shorter than a programmable number of cycles and delivers a clean registered level that drives the edge detector's a_i.
- Also flags rejected glitches and reports when a level change is being qualified.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on a_raw_i; legal values are 2 or more.
- DEBOUNCE_CYCLES, 4, number of consecutive equal synchronized samples needed to accept a new level; legal values are 2 or more.
- RESET_VAL, 1'b0, level of a_o and of every synchronizer flop while in reset.

Ports:
- clk  input  1  single system clock; all logic uses the rising edge.
- reset  input  1  asynchronous, active-low reset; assertion is immediate, deassertion is synchronized to clk outside this block.
- a_raw_i  input  1  raw asynchronous level.
- a_o  output  1  debounced, registered level; connects to the edge detector's a_i.
- busy_o  output  1  high while a candidate level change is being qualified.
- glitch_o  output  1  one-cycle pulse when a candidate change is rejected.

Behaviour:
- All outputs are registered. In reset: a_o=RESET_VAL, busy_o=0, glitch_o=0, sync chain=RESET_VAL, cnt=0, state=STABLE_HI if RESET_VAL else STABLE_LO.
- The synchronizer chain produces s, the last stage. The FSM samples s on every edge.
- FSM states are STABLE_LO, CHK_HI, STABLE_HI and CHK_LO.
- STABLE_LO:
  - s=1 -> go to CHK_HI, cnt<=1, busy_o<=1.
  - otherwise hold.
- CHK_HI:
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> go to STABLE_HI, a_o<=1, busy_o<=0, cnt<=0.
  - s=1 otherwise -> cnt<=cnt+1.
  - s=0 -> go to STABLE_LO, cnt<=0, busy_o<=0, glitch_o<=1 for exactly one cycle; a_o is unchanged.
- STABLE_HI and CHK_LO mirror the above with the polarity inverted.
- glitch_o is 0 in every cycle not listed above.
- Counter width is $clog2(DEBOUNCE_CYCLES). cnt never exceeds DEBOUNCE_CYCLES-1 and has no wrap-around.
- Latency: count the first edge that samples the new raw level as edge 1. a_o changes at edge SYNC_STAGES+DEBOUNCE_CYCLES, which is 6 with default parameters. Rise and fall latency are identical.
- Acceptance rule: a raw level held for at least DEBOUNCE_CYCLES sampled edges is accepted. A level held for DEBOUNCE_CYCLES-1 edges or fewer is rejected.
- Back-to-back changes: a candidate that aborts returns to the stable state. A later change starts a fresh count with no dead cycle.
- Reset mid-qualification: outputs go to their reset values immediately, and any partial count is discarded.
- Metastability is confined to the synchronizer chain. No logic other than the next synchronizer stage reads the first stage.

Decomposition:
- debounce_pkg holds:
  - typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} deb_state_t;
  - localparam int DEB_MIN_CYCLES = 2 for parameter checks.
- One sub-module, bit_synchronizer:
  - parameters STAGES and RESET_VAL;
  - ports clk, reset, d_i, q_o;
  - reused by other pin-input blocks.
- Elaboration-time assertions reject SYNC_STAGES<2 and DEBOUNCE_CYCLES<DEB_MIN_CYCLES.

Test Plan (default parameters unless stated):
- Async reset: drive reset=0 between clock edges -> a_o=0, busy_o=0, glitch_o=0 immediately, before the next edge.
- Clean rise: a_raw_i 0->1 held for 10 cycles -> busy_o=1 from edge 3 to edge 6; a_o=1 from edge 6 onward; glitch_o never asserts.
- Boundary pulses:
  - a_raw_i high for exactly 3 sampled edges -> a_o stays 0; glitch_o pulses for one cycle after edge 6.
  - a_raw_i high for exactly 4 sampled edges -> a_o rises at edge 6, falls at edge 10, and is high for 4 cycles.
- Glitch on falling side: with a_o=1, a_raw_i drops for 1 cycle -> a_o stays 1; exactly one glitch_o pulse, after edge 4.
- Reset mid-qualification: with a_raw_i=1, assert reset at edge 4 while busy_o=1 -> a_o=0 and busy_o=0 at once. Release reset with a_raw_i still 1 -> a_o rises at the 6th edge after release.
- RESET_VAL=1 instance: after reset a_o=1; then a_raw_i held at 0 -> a_o falls at edge 6; a downstream edge detector sees exactly one falling edge.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared types and limits for the pin-input debounce blocks.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO,
      CHK_HI,
      STABLE_HI,
      CHK_LO
   } deb_state_t;

   localparam int DEB_MIN_CYCLES = 2;

endpackage

// File: rtl/input_debouncer_sync.sv
// Multi-flop level synchronizer for a single asynchronous input bit.
// Only the next stage reads each flop, so metastability stays inside the chain.
module bit_synchronizer
   import debounce_pkg::*;
#(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw level through the chain; all stages load RESET_VAL in reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes a raw pin level and accepts a new level only after it has been
// seen for DEBOUNCE_CYCLES consecutive samples; aborted candidates pulse glitch_o.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic a_raw_i,
   output logic a_o,
   output logic busy_o,
   output logic glitch_o
);

   localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam deb_state_t     RST_ST  = RESET_VAL ? STABLE_HI : STABLE_LO;

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("input_debouncer: SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < DEB_MIN_CYCLES) begin : g_bad_deb
      $error("input_debouncer: DEBOUNCE_CYCLES below DEB_MIN_CYCLES");
   end

   logic          s;
   deb_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          a_q, a_d;
   logic          busy_q, busy_d;
   logic          glitch_q, glitch_d;

   bit_synchronizer #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (RESET_VAL)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (a_raw_i),
      .q_o   (s)
   );

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= RST_ST;
         cnt_q    <= '0;
         a_q      <= RESET_VAL;
         busy_q   <= 1'b0;
         glitch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         busy_q   <= busy_d;
         glitch_q <= glitch_d;
      end
   end

   // Qualify candidate level changes; glitch is a single-cycle pulse on abort.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      busy_d   = busy_q;
      glitch_d = 1'b0;
      unique case (state_q)
         STABLE_LO: begin
            if (s) begin
               state_d = CHK_HI;
               cnt_d   = CW'(1);
               busy_d  = 1'b1;
            end
         end
         CHK_HI: begin
            if (s) begin
               if (cnt_q == CNT_MAX) begin
                  state_d = STABLE_HI;
                  a_d     = 1'b1;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d  = STABLE_LO;
               cnt_d    = '0;
               busy_d   = 1'b0;
               glitch_d = 1'b1;
            end
         end
         STABLE_HI: begin
            if (!s) begin
               state_d = CHK_LO;
               cnt_d   = CW'(1);
               busy_d  = 1'b1;
            end
         end
         CHK_LO: begin
            if (!s) begin
               if (cnt_q == CNT_MAX) begin
                  state_d = STABLE_LO;
                  a_d     = 1'b0;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d  = STABLE_HI;
               cnt_d    = '0;
               busy_d   = 1'b0;
               glitch_d = 1'b1;
            end
         end
         default: begin
            state_d = RST_ST;
            cnt_d   = '0;
         end
      endcase
   end

   assign a_o      = a_q;
   assign busy_o   = busy_q;
   assign glitch_o = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: default instance plus a RESET_VAL=1 instance.
module tb_input_debouncer;

   logic clk;
   logic rst_n;
   logic raw0, raw1;
   logic a0, busy0, glitch0;
   logic a1, busy1, glitch1;

   int vectors = 0;
   int errors  = 0;

   input_debouncer #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .RESET_VAL       (1'b0)
   ) dut0 (
      .clk      (clk),
      .reset    (rst_n),
      .a_raw_i  (raw0),
      .a_o      (a0),
      .busy_o   (busy0),
      .glitch_o (glitch0)
   );

   input_debouncer #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .RESET_VAL       (1'b1)
   ) dut1 (
      .clk      (clk),
      .reset    (rst_n),
      .a_raw_i  (raw1),
      .a_o      (a1),
      .busy_o   (busy1),
      .glitch_o (glitch1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance past the next rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      raw0  = 1'b0;
      raw1  = 1'b1;
      #12;
      vectors++;
      if (a0 !== 1'b0 || busy0 !== 1'b0 || glitch0 !== 1'b0) begin
         errors++;
         $display("FAIL reset0: got a=%b busy=%b glitch=%b want 0 0 0", a0, busy0, glitch0);
      end
      vectors++;
      if (a1 !== 1'b1 || busy1 !== 1'b0 || glitch1 !== 1'b0) begin
         errors++;
         $display("FAIL reset1: got a=%b busy=%b glitch=%b want 1 0 0", a1, busy1, glitch1);
      end
      @(negedge clk) rst_n = 1'b1;
      // Take a_o high, then assert reset between edges and look before the next edge.
      @(negedge clk) raw0 = 1'b1;
      idle(8);
      vectors++;
      if (a0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_high: got a=%b want 1", a0);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (a0 !== 1'b0 || busy0 !== 1'b0 || glitch0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got a=%b busy=%b glitch=%b want 0 0 0", a0, busy0, glitch0);
      end
      raw0 = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      idle(4);
   endtask

   task automatic test_clean_rise();
      logic exp_busy;
      @(negedge clk) raw0 = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         exp_busy = (e >= 3 && e <= 5);
         vectors++;
         if (a0 !== (e >= 6) || busy0 !== exp_busy || glitch0 !== 1'b0) begin
            errors++;
            $display("FAIL rise edge %0d: got a=%b busy=%b glitch=%b want %b %b 0",
                     e, a0, busy0, glitch0, (e >= 6), exp_busy);
         end
      end
      @(negedge clk) raw0 = 1'b0;
      idle(10);
   endtask

   task automatic test_pulse3();
      @(negedge clk) raw0 = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         if (e == 3) raw0 = 1'b0;
         vectors++;
         if (a0 !== 1'b0 || busy0 !== (e >= 3 && e <= 5) || glitch0 !== (e == 6)) begin
            errors++;
            $display("FAIL pulse3 edge %0d: got a=%b busy=%b glitch=%b want 0 %b %b",
                     e, a0, busy0, glitch0, (e >= 3 && e <= 5), (e == 6));
         end
      end
      idle(3);
   endtask

   task automatic test_pulse4();
      int  high_cnt;
      logic exp_busy;
      high_cnt = 0;
      @(negedge clk) raw0 = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         step();
         if (e == 4) raw0 = 1'b0;
         if (a0 === 1'b1) high_cnt++;
         exp_busy = (e >= 3 && e <= 5) || (e >= 7 && e <= 9);
         vectors++;
         if (a0 !== (e >= 6 && e <= 9) || busy0 !== exp_busy || glitch0 !== 1'b0) begin
            errors++;
            $display("FAIL pulse4 edge %0d: got a=%b busy=%b glitch=%b want %b %b 0",
                     e, a0, busy0, glitch0, (e >= 6 && e <= 9), exp_busy);
         end
      end
      vectors++;
      if (high_cnt != 4) begin
         errors++;
         $display("FAIL pulse4_width: got %0d cycles want 4", high_cnt);
      end
      idle(3);
   endtask

   task automatic test_fall_glitch();
      int pulses;
      pulses = 0;
      @(negedge clk) raw0 = 1'b1;
      idle(8);
      @(negedge clk) raw0 = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         step();
         if (e == 1) raw0 = 1'b1;
         if (glitch0 === 1'b1) pulses++;
         vectors++;
         if (a0 !== 1'b1 || busy0 !== (e == 3) || glitch0 !== (e == 4)) begin
            errors++;
            $display("FAIL fall_glitch edge %0d: got a=%b busy=%b glitch=%b want 1 %b %b",
                     e, a0, busy0, glitch0, (e == 3), (e == 4));
         end
      end
      vectors++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL fall_glitch_count: got %0d want 1", pulses);
      end
      @(negedge clk) raw0 = 1'b0;
      idle(10);
   endtask

   task automatic test_reset_mid();
      @(negedge clk) raw0 = 1'b1;
      idle(4);
      vectors++;
      if (busy0 !== 1'b1 || a0 !== 1'b0) begin
         errors++;
         $display("FAIL mid_pre: got a=%b busy=%b want 0 1", a0, busy0);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (a0 !== 1'b0 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got a=%b busy=%b want 0 0", a0, busy0);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         vectors++;
         if (a0 !== (e >= 6)) begin
            errors++;
            $display("FAIL mid_release edge %0d: got a=%b want %b", e, a0, (e >= 6));
         end
      end
      @(negedge clk) raw0 = 1'b0;
      idle(10);
   endtask

   task automatic test_resetval1();
      logic prev;
      int   falls, rises;
      falls = 0;
      rises = 0;
      prev  = a1;
      vectors++;
      if (a1 !== 1'b1) begin
         errors++;
         $display("FAIL rv1_start: got a=%b want 1", a1);
      end
      @(negedge clk) raw1 = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         step();
         if (prev === 1'b1 && a1 === 1'b0) falls++;
         if (prev === 1'b0 && a1 === 1'b1) rises++;
         prev = a1;
         vectors++;
         if (a1 !== (e < 6) || glitch1 !== 1'b0) begin
            errors++;
            $display("FAIL rv1 edge %0d: got a=%b glitch=%b want %b 0", e, a1, glitch1, (e < 6));
         end
      end
      vectors++;
      if (falls != 1 || rises != 0) begin
         errors++;
         $display("FAIL rv1_edges: got falls=%0d rises=%0d want 1 0", falls, rises);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      raw0  = 1'b0;
      raw1  = 1'b1;
      test_reset();
      test_clean_rise();
      test_pulse3();
      test_pulse4();
      test_fall_glitch();
      test_reset_mid();
      test_resetval1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
